// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the memory port arbiter and
// the single-port unified memory. The slave view belongs to the arbiter; the
// master view belongs to whatever drives requests and models the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
);

  // instruction-fetch requester (always a read)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;

  // data load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;

  // read data returned to whichever requester won
  logic [DATA_W-1:0] rdata;

  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, d_gnt, d_rvalid, rdata,
           mem_addr, mem_wdata, mem_re, mem_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, d_gnt, d_rvalid, rdata,
           mem_addr, mem_wdata, mem_re, mem_we, busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the instruction-fetch and
// data load/store paths. One access at a time: IDLE -> ISSUE -> (WAIT x
// MEM_LAT -> RESP) for reads, IDLE -> ISSUE -> IDLE for writes.
// Contention is resolved data-over-fetch; define ARB_RR_EN to alternate
// between requesters on contention instead.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  // Counter holds MEM_LAT-1 down to 0; keep at least one bit.
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              src_q, src_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic              pick_data;
  logic              issue_d;
  logic              resp_d;

`ifdef ARB_RR_EN
  logic              last_q, last_d;

  // On contention the requester not granted last wins; a sole requester wins.
  always_comb begin
    pick_data = bus.d_req && (!bus.if_req || (last_q == SRC_FETCH));
  end

  // Remember who was granted at each IDLE -> ISSUE hand-off.
  always_comb begin
    last_d = last_q;
    if ((state_q == S_IDLE) && (state_d == S_ISSUE)) begin
      last_d = src_d;
    end
  end

  // Last-granted register; starts at fetch so the first contention goes to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SRC_FETCH;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  assign pick_data = bus.d_req;
`endif

  // Next-state, latched request fields and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    src_d   = src_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d = S_ISSUE;
          if (pick_data) begin
            src_d   = SRC_DATA;
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
          end else begin
            src_d   = SRC_FETCH;
            addr_d  = bus.if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    issue_d     = (state_d == S_ISSUE);
    resp_d      = (state_d == S_RESP);
    if_gnt_d    = issue_d && (src_d == SRC_FETCH);
    d_gnt_d     = issue_d && (src_d == SRC_DATA);
    mem_re_d    = issue_d && !we_d;
    mem_we_d    = issue_d && we_d;
    if_rvalid_d = resp_d && (src_d == SRC_FETCH);
    d_rvalid_d  = resp_d && (src_d == SRC_DATA);
    busy_d      = (state_d != S_IDLE);
  end

  // State, latched fields and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      src_q       <= SRC_FETCH;
      rdata_q     <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      src_q       <= src_d;
      rdata_q     <= rdata_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = rdata_q;

  // Only one requester is ever granted or answered, and memory never sees both strobes.
  a_gnt_excl:    assert property (@(posedge clk) disable iff (rst) !(if_gnt_q && d_gnt_q));
  a_rvalid_excl: assert property (@(posedge clk) disable iff (rst) !(if_rvalid_q && d_rvalid_q));
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_re_q && mem_we_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) with a
// transaction-timeline model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
  } drv_t;

  typedef struct packed {
    logic          if_gnt;
    logic          if_rvalid;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic          mem_we;
    logic          busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  drv_t          drv [2];
  obs_t          obs [2];
  logic [DW-1:0] mrd [2];

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign {bus1.if_req, bus1.if_addr, bus1.d_req, bus1.d_we, bus1.d_addr, bus1.d_wdata} = drv[0];
  assign {bus3.if_req, bus3.if_addr, bus3.d_req, bus3.d_we, bus3.d_addr, bus3.d_wdata} = drv[1];
  assign bus1.mem_rdata = mrd[0];
  assign bus3.mem_rdata = mrd[1];
  assign obs[0] = {bus1.if_gnt, bus1.if_rvalid, bus1.d_gnt, bus1.d_rvalid, bus1.rdata,
                   bus1.mem_addr, bus1.mem_wdata, bus1.mem_re, bus1.mem_we, bus1.busy};
  assign obs[1] = {bus3.if_gnt, bus3.if_rvalid, bus3.d_gnt, bus3.d_rvalid, bus3.rdata,
                   bus3.mem_addr, bus3.mem_wdata, bus3.mem_re, bus3.mem_we, bus3.busy};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane=%0d cyc=%0d got=%0h want=%0h", name, l, cyc, act, exp);
    end
  endtask

  // cycle counter, stepped at each rising edge
  initial begin : p_cyc
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: write on mem_we, read data present only MEM_LAT cycles after mem_re.
  logic [DW-1:0] bmem [2][8192];
  logic          iss_v [2];
  int            iss_cyc [2];
  logic [AW-1:0] iss_a [2];

  initial begin : p_mem
    for (int l = 0; l < 2; l++) begin
      for (int a = 0; a < 8192; a++) bmem[l][a] = 8'(a) ^ 8'hB5;
      iss_v[l] = 1'b0;
      iss_cyc[l] = 0;
      iss_a[l] = '0;
      mrd[l] = 8'hEE;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        if (iss_v[l] && (cyc == iss_cyc[l] + lat(l))) begin
          mrd[l] = bmem[l][iss_a[l]];
          iss_v[l] = 1'b0;
        end else begin
          mrd[l] = 8'hEE;
        end
        if (rst) iss_v[l] = 1'b0;
        if (obs[l].mem_re) begin
          iss_v[l] = 1'b1;
          iss_cyc[l] = cyc;
          iss_a[l] = obs[l].mem_addr;
        end
        if (obs[l].mem_we) bmem[l][obs[l].mem_addr] = obs[l].mem_wdata;
      end
    end
  end

  // Timeline model: an accepted request occupies the port for a fixed number
  // of cycles; outputs are a function of the offset into that window.
  logic          m_act [2];
  logic          m_rd [2];
  logic          m_src [2];
  logic          m_last [2];
  int            m_off [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wd [2];
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] mmem [2][8192];

  task automatic model_reset(input int l);
    m_act[l] = 1'b0; m_rd[l] = 1'b0; m_src[l] = 1'b0; m_last[l] = 1'b0;
    m_off[l] = 0; m_addr[l] = '0; m_wd[l] = '0; m_rdata[l] = '0;
  endtask

  task automatic model_step(input int l);
    logic take_d;
    int   dur;
    if (rst) begin
      model_reset(l);
    end else if (m_act[l]) begin
      m_off[l]++;
      dur = m_rd[l] ? lat(l) + 3 : 2;
      if (m_rd[l] && (m_off[l] == lat(l) + 2)) m_rdata[l] = mmem[l][m_addr[l]];
      if (m_off[l] == dur) m_act[l] = 1'b0;
    end else if (drv[l].if_req || drv[l].d_req) begin
`ifdef ARB_RR_EN
      take_d = drv[l].d_req && (!drv[l].if_req || !m_last[l]);
`else
      take_d = drv[l].d_req;
`endif
      m_src[l]  = take_d;
      m_last[l] = take_d;
      m_act[l]  = 1'b1;
      m_off[l]  = 1;
      m_rd[l]   = take_d ? !drv[l].d_we : 1'b1;
      m_addr[l] = take_d ? drv[l].d_addr : drv[l].if_addr;
      m_wd[l]   = take_d ? drv[l].d_wdata : '0;
      if (!m_rd[l]) mmem[l][m_addr[l]] = m_wd[l];
    end
  endtask

  task automatic compare_lane(input int l);
    obs_t o;
    logic g1, rv;
    o  = obs[l];
    g1 = m_act[l] && (m_off[l] == 1);
    rv = m_act[l] && m_rd[l] && (m_off[l] == lat(l) + 2);
    check("if_gnt",    l, 32'(o.if_gnt),    32'(g1 && !m_src[l]));
    check("d_gnt",     l, 32'(o.d_gnt),     32'(g1 && m_src[l]));
    check("if_rvalid", l, 32'(o.if_rvalid), 32'(rv && !m_src[l]));
    check("d_rvalid",  l, 32'(o.d_rvalid),  32'(rv && m_src[l]));
    check("mem_re",    l, 32'(o.mem_re),    32'(g1 && m_rd[l]));
    check("mem_we",    l, 32'(o.mem_we),    32'(g1 && !m_rd[l]));
    check("busy",      l, 32'(o.busy),      32'(m_act[l]));
    check("rdata",     l, 32'(o.rdata),     32'(m_rdata[l]));
    check("mem_addr",  l, 32'(o.mem_addr),  32'(m_addr[l]));
    if (g1 && !m_rd[l]) check("mem_wdata", l, 32'(o.mem_wdata), 32'(m_wd[l]));
  endtask

  initial begin : p_model
    for (int l = 0; l < 2; l++) begin
      model_reset(l);
      for (int a = 0; a < 8192; a++) mmem[l][a] = 8'(a) ^ 8'hB5;
    end
    forever begin
      @(posedge clk);
      for (int l = 0; l < 2; l++) model_step(l);
      #1;
      for (int l = 0; l < 2; l++) compare_lane(l);
    end
  end

  // Directed requester helpers; inputs change on the falling edge.
  int            g_off, r_off, f_off, d_off, re_cnt;
  logic          g_re, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd, r_data;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_req(input int l, input logic is_d, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int n;
    n = cyc;
    g_off = -1; r_off = -1; re_cnt = 0;
    g_re = 1'b0; g_we = 1'b0; g_addr = '0; g_wd = '0; r_data = '0;
    if (is_d) begin
      drv[l].d_req = 1'b1; drv[l].d_we = we; drv[l].d_addr = a; drv[l].d_wdata = wd;
    end else begin
      drv[l].if_req = 1'b1; drv[l].if_addr = a;
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (obs[l].mem_re) re_cnt++;
      if ((g_off < 0) && (is_d ? obs[l].d_gnt : obs[l].if_gnt)) begin
        g_off = cyc - n;
        g_re = obs[l].mem_re; g_we = obs[l].mem_we;
        g_addr = obs[l].mem_addr; g_wd = obs[l].mem_wdata;
        if (is_d) drv[l].d_req = 1'b0; else drv[l].if_req = 1'b0;
        if (is_d && we) break;
      end
      if (is_d ? obs[l].d_rvalid : obs[l].if_rvalid) begin
        r_off = cyc - n;
        r_data = obs[l].rdata;
        break;
      end
    end
    if ((g_off < 0) || (!(is_d && we) && (r_off < 0))) begin
      total++; bad++;
      $display("FAIL req_timeout lane=%0d got=no_response want=response", l);
      drv[l].d_req = 1'b0; drv[l].if_req = 1'b0;
    end
  endtask

  task automatic contend(input int l, input logic [AW-1:0] fa, input logic [AW-1:0] da);
    int n;
    n = cyc;
    f_off = -1; d_off = -1;
    drv[l].if_req = 1'b1; drv[l].if_addr = fa;
    drv[l].d_req = 1'b1; drv[l].d_we = 1'b0; drv[l].d_addr = da;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (obs[l].if_gnt) begin f_off = cyc - n; drv[l].if_req = 1'b0; end
      if (obs[l].d_gnt)  begin d_off = cyc - n; drv[l].d_req = 1'b0; end
      if ((f_off >= 0) && (d_off >= 0) && !obs[l].busy) break;
    end
    r_data = obs[l].rdata;
    if ((f_off < 0) || (d_off < 0) || obs[l].busy) begin
      total++; bad++;
      $display("FAIL contend_timeout lane=%0d got=f%0d_d%0d want=both_granted", l, f_off, d_off);
      drv[l].d_req = 1'b0; drv[l].if_req = 1'b0;
    end
  endtask

  initial begin : p_main
    int hits;
    int n;
    for (int l = 0; l < 2; l++) drv[l] = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset then 10 quiet cycles
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++)
        if (obs[l].busy || obs[l].mem_re || obs[l].mem_we || obs[l].if_gnt ||
            obs[l].d_gnt || obs[l].if_rvalid || obs[l].d_rvalid) hits++;
    end
    check("idle_quiet", 0, 32'(hits), 32'd0);
    check("rst_rdata", 0, 32'(obs[0].rdata), 32'd0);
    check("rst_mem_addr", 1, 32'(obs[1].mem_addr), 32'd0);

    // first contention after reset: data first in both builds
    contend(0, 13'h020, 13'h030);
    check("c1_d_off", 0, 32'(d_off), 32'd1);
    check("c1_f_off", 0, 32'(f_off), 32'd5);
    check("c1_rdata", 0, 32'(r_data), 32'h95);
    idle(2);

    // fetch read, MEM_LAT=1
    do_req(0, 1'b0, 1'b0, 13'h010, 8'h00);
    check("f_gnt_off", 0, 32'(g_off), 32'd1);
    check("f_gnt_re", 0, 32'(g_re), 32'd1);
    check("f_gnt_addr", 0, 32'(g_addr), 32'h010);
    check("f_rv_off", 0, 32'(r_off), 32'd3);
    check("f_rdata", 0, 32'(r_data), 32'hA5);
    idle(2);

    // data write then read-back
    do_req(0, 1'b1, 1'b1, 13'h1F0, 8'h3C);
    check("w_gnt_off", 0, 32'(g_off), 32'd1);
    check("w_gnt_we", 0, 32'(g_we), 32'd1);
    check("w_gnt_wdata", 0, 32'(g_wd), 32'h3C);
    check("w_gnt_addr", 0, 32'(g_addr), 32'h1F0);
    @(negedge clk);
    check("w_busy_c2", 0, 32'(obs[0].busy), 32'd0);
    check("w_rdata_kept", 0, 32'(obs[0].rdata), 32'hA5);
    idle(2);
    do_req(0, 1'b1, 1'b0, 13'h1F0, 8'h00);
    check("rb_rv_off", 0, 32'(r_off), 32'd3);
    check("rb_rdata", 0, 32'(r_data), 32'h3C);
    idle(2);

    // contention after a data grant
    contend(0, 13'h040, 13'h050);
`ifdef ARB_RR_EN
    check("c2_f_off", 0, 32'(f_off), 32'd1);
    check("c2_d_off", 0, 32'(d_off), 32'd5);
    check("c2_rdata", 0, 32'(r_data), 32'hE5);
`else
    check("c2_d_off", 0, 32'(d_off), 32'd1);
    check("c2_f_off", 0, 32'(f_off), 32'd5);
    check("c2_rdata", 0, 32'(r_data), 32'hF5);
`endif
    idle(2);

    // fetch read, MEM_LAT=3
    do_req(1, 1'b0, 1'b0, 13'h0A0, 8'h00);
    check("l3_gnt_off", 1, 32'(g_off), 32'd1);
    check("l3_rv_off", 1, 32'(r_off), 32'd5);
    check("l3_re_cnt", 1, 32'(re_cnt), 32'd1);
    check("l3_rdata", 1, 32'(r_data), 32'h15);
    idle(2);

    // reset asserted while a read waits on memory
    n = cyc;
    drv[1].d_req = 1'b1; drv[1].d_we = 1'b0; drv[1].d_addr = 13'h0B0;
    @(negedge clk);
    check("rw_gnt", 1, 32'(obs[1].d_gnt), 32'd1);
    check("rw_gnt_off", 1, 32'(cyc - n), 32'd1);
    drv[1].d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (obs[1].d_rvalid || obs[1].if_rvalid || obs[1].busy) hits++;
    end
    check("rw_no_rvalid", 1, 32'(hits), 32'd0);
    check("rw_rdata", 1, 32'(obs[1].rdata), 32'd0);
    check("rw_rdata_l1", 0, 32'(obs[0].rdata), 32'd0);
    do_req(1, 1'b0, 1'b0, 13'h0C0, 8'h00);
    check("rw_next_rv_off", 1, 32'(r_off), 32'd5);
    check("rw_next_rdata", 1, 32'(r_data), 32'h75);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
